// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, command opcodes
// and response codes as seen on the memory-host beat interface.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    localparam logic [1:0] CMD_READ       = 2'b10;
    localparam logic [1:0] CMD_SET_ADDR   = 2'b01;
    localparam logic [1:0] CMD_WRITE_DATA = 2'b11;

    localparam logic [1:0] RSP_WR_ACK  = 2'b00;
    localparam logic [1:0] RSP_RD_DATA = 2'b01;

    // Any code with the top bit set is an error, whatever the low bit says.
    function automatic logic rsp_is_err(input logic [1:0] code);
        return (code != RSP_WR_ACK) && (code != RSP_RD_DATA);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Saturating 8-bit wait counter for the response phase; expired fires in the
// WAIT_RSP cycle whose increment brings the count up to TIMEOUT.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= 8'd0;
        end else if (clear) begin
            count_reg <= 8'd0;
        end else if (enable && (count_reg != 8'hFF)) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting a fetch port and a data port access to a single
// beat-based memory host, one transaction outstanding at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        cmd_stb,
    output logic [33:0] cmd_word,
    input  logic        cmd_busy,
    input  logic        rsp_stb,
    input  logic [33:0] rsp_word
);

    state_t      state_reg;
    logic        gnt_data_reg;
    logic        last_data_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;

    logic        grant_data;
    logic        accept;
    logic        expired;
    logic [31:0] done_rdata;
    logic        done_err;

    // Data wins a tie only when fetch was the most recent grant.
    always_comb begin
        grant_data = d_req && (!f_req || !last_data_reg);
        accept     = cmd_stb && !cmd_busy;
        done_err   = 1'b1;
        done_rdata = 32'h0;
        if (rsp_stb) begin
            done_err = rsp_is_err(rsp_word[33:32]);
            if (!we_reg && (rsp_word[33:32] != RSP_WR_ACK)) begin
                done_rdata = rsp_word[31:0];
            end
        end
    end

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_reg == ST_DATA) && accept),
        .enable (state_reg == ST_WAIT_RSP),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            gnt_data_reg  <= 1'b0;
            last_data_reg <= 1'b1;
            we_reg        <= 1'b0;
            wdata_reg     <= 32'h0;
            cmd_stb       <= 1'b0;
            cmd_word      <= 34'h0;
            f_ack         <= 1'b0;
            f_rdata       <= 32'h0;
            f_err         <= 1'b0;
            d_ack         <= 1'b0;
            d_rdata       <= 32'h0;
            d_err         <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        gnt_data_reg  <= grant_data;
                        last_data_reg <= grant_data;
                        we_reg        <= grant_data && d_we;
                        wdata_reg     <= d_wdata;
                        cmd_stb       <= 1'b1;
                        if (grant_data && d_we) begin
                            cmd_word  <= {CMD_SET_ADDR, d_addr};
                            state_reg <= ST_ADDR;
                        end else begin
                            cmd_word  <= {CMD_READ, (grant_data ? d_addr : f_addr)};
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_ADDR: begin
                    if (accept) begin
                        cmd_word  <= {CMD_WRITE_DATA, wdata_reg};
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        cmd_stb   <= 1'b0;
                        state_reg <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    // A response arriving in the expiry cycle still wins.
                    if (rsp_stb || expired) begin
                        if (gnt_data_reg) begin
                            d_ack   <= 1'b1;
                            d_rdata <= done_rdata;
                            d_err   <= done_err;
                        end else begin
                            f_ack   <= 1'b1;
                            f_rdata <= done_rdata;
                            f_err   <= done_err;
                        end
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
